// File: rtl/alorium_lfsr_pkg.sv
// Shared LFSR definitions: XNOR generator step, tap set and checker state encoding.
// Used by both the pattern generator and the checker.
package alorium_lfsr_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } lfsr_state_e;

  localparam logic [7:0] LFSR_TAPS   = 8'hB8;  // bits 7,5,4,3
  localparam logic [7:0] LFSR_SEED   = 8'h01;
  localparam logic [7:0] LFSR_LOCKUP = 8'hFF;  // XNOR lock-up value, never valid

  function automatic logic [7:0] step(input logic [7:0] d);
    return {d[6:0], ~(d[7] ^ d[5] ^ d[4] ^ d[3])};
  endfunction

endpackage

// File: rtl/alorium_lfsr_chk.sv
// LFSR pattern checker: self-synchronises in HUNT, then flywheels the expected
// sequence in LOCKED and reports/counts mismatched samples.
module alorium_lfsr_chk
  import alorium_lfsr_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned LOSS_CNT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        data_valid,
  input  logic [7:0]  rx_data,
  input  logic        clear_cnt,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_count
);

  lfsr_state_e state_q, state_d;
  logic [7:0]  ref_q, ref_d;
  logic        first_q, first_d;
  logic [7:0]  good_cnt_q, good_cnt_d;
  logic [7:0]  miss_cnt_q, miss_cnt_d;
  logic        locked_q, locked_d;
  logic        err_pulse_q, err_pulse_d;
  logic [15:0] err_count_q, err_count_d;

  logic [7:0]  pred;
  logic        match;
  logic [7:0]  good_inc;
  logic [7:0]  miss_inc;

  assign pred     = step(ref_q);
  assign match    = (rx_data == pred) && (rx_data != LFSR_LOCKUP);
  assign good_inc = good_cnt_q + 8'd1;
  assign miss_inc = (miss_cnt_q == 8'hFF) ? miss_cnt_q : miss_cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    first_d     = first_q;
    good_cnt_d  = good_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;

    if (data_valid) begin
      unique case (state_q)
        HUNT: begin
          ref_d = rx_data;
          if (first_q) begin
            first_d = 1'b0;
          end else if (!match) begin
            good_cnt_d = '0;
          end else if (good_inc == 8'(LOCK_CNT)) begin
            state_d    = LOCKED;
            good_cnt_d = '0;
            miss_cnt_d = '0;
          end else begin
            good_cnt_d = good_inc;
          end
        end
        LOCKED: begin
          // Flywheel: prediction advances regardless of what was received.
          ref_d = pred;
          if (match) begin
            miss_cnt_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + 16'd1;
            if ((LOSS_CNT != 0) && (miss_inc == 8'(LOSS_CNT))) begin
              state_d    = HUNT;
              first_d    = 1'b1;
              good_cnt_d = '0;
              miss_cnt_d = '0;
            end else begin
              miss_cnt_d = miss_inc;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (clear_cnt) err_count_d = '0;
  end

  assign locked_d = (state_d == LOCKED);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= HUNT;
      ref_q       <= LFSR_SEED;
      first_q     <= 1'b1;
      good_cnt_q  <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      first_q     <= first_d;
      good_cnt_q  <= good_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_alorium_lfsr_chk.sv
// Scoreboard bench for alorium_lfsr_chk: a LOSS_CNT=4 instance for acquisition,
// error, loss, gap and reset scenarios, and a LOSS_CNT=0 instance for saturation.
module tb_alorium_lfsr_chk;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rn0 = 1'b0, dv0 = 1'b0, clr0 = 1'b0;
  logic [7:0]  rx0 = '0;
  logic        lk0, ep0;
  logic [15:0] ec0;
  logic        rn1 = 1'b0, dv1 = 1'b0, clr1 = 1'b0;
  logic [7:0]  rx1 = '0;
  logic        lk1, ep1;
  logic [15:0] ec1;

  alorium_lfsr_chk #(.LOCK_CNT(8), .LOSS_CNT(4)) dut0 (
    .clk(clk), .reset_n(rn0), .data_valid(dv0), .rx_data(rx0), .clear_cnt(clr0),
    .locked(lk0), .err_pulse(ep0), .err_count(ec0)
  );

  alorium_lfsr_chk #(.LOCK_CNT(8), .LOSS_CNT(0)) dut1 (
    .clk(clk), .reset_n(rn1), .data_valid(dv1), .rx_data(rx1), .clear_cnt(clr1),
    .locked(lk1), .err_pulse(ep1), .err_count(ec1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int          sel;
    logic        lk;
    logic        ep;
    logic [15:0] ec;
  } exp_t;
  exp_t sb[$];

  // Reference model state, one slot per DUT instance
  bit         m_lock[2];
  bit         m_first[2];
  logic [7:0] m_ref[2];
  int         m_good[2];
  int         m_miss[2];
  int         m_cnt[2];
  int         m_loss[2] = '{4, 0};

  function automatic logic [7:0] nxt(input logic [7:0] d);
    logic [7:0] sh;
    sh = (d << 1) & 8'hFE;
    return sh | {7'd0, ~^(d & 8'hB8)};
  endfunction

  task automatic drive(input int s, input bit rst, input bit v, input logic [7:0] d, input bit clr);
    exp_t       e;
    logic [7:0] pred;
    bit         ok;
    bit         pulse;
    @(negedge clk);
    if (s == 0) begin
      rn0 = !rst; dv0 = v; rx0 = d; clr0 = clr;
    end else begin
      rn1 = !rst; dv1 = v; rx1 = d; clr1 = clr;
    end
    pulse = 1'b0;
    if (rst) begin
      m_lock[s] = 0; m_first[s] = 1; m_ref[s] = 8'h01;
      m_good[s] = 0; m_miss[s] = 0; m_cnt[s] = 0;
    end else begin
      if (v) begin
        pred = nxt(m_ref[s]);
        ok   = (d == pred) && (d != 8'hFF);
        if (!m_lock[s]) begin
          if (m_first[s]) m_first[s] = 0;
          else begin
            m_good[s] = ok ? m_good[s] + 1 : 0;
            if (m_good[s] == 8) begin
              m_lock[s] = 1; m_good[s] = 0; m_miss[s] = 0;
            end
          end
          m_ref[s] = d;
        end else begin
          m_ref[s] = pred;
          if (ok) m_miss[s] = 0;
          else begin
            pulse = 1'b1;
            if (m_cnt[s] < 65535) m_cnt[s]++;
            m_miss[s]++;
            if (m_loss[s] != 0 && m_miss[s] == m_loss[s]) begin
              m_lock[s] = 0; m_first[s] = 1; m_good[s] = 0; m_miss[s] = 0;
            end
          end
        end
      end
      if (clr) m_cnt[s] = 0;
    end
    e.sel = s; e.lk = m_lock[s]; e.ep = pulse; e.ec = 16'(m_cnt[s]);
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.sel == 0) begin
          check_val("sb0_locked", 32'(lk0), 32'(e.lk));
          check_val("sb0_err_pulse", 32'(ep0), 32'(e.ep));
          check_val("sb0_err_count", 32'(ec0), 32'(e.ec));
        end else begin
          check_val("sb1_locked", 32'(lk1), 32'(e.lk));
          check_val("sb1_err_pulse", 32'(ep1), 32'(e.ep));
          check_val("sb1_err_count", 32'(ec1), 32'(e.ec));
        end
      end
    end
  end

  logic [7:0] g;

  task automatic send(input int s, input logic [7:0] d);
    drive(s, 1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic gap(input int s, input int n);
    for (int i = 0; i < n; i++) drive(s, 1'b0, 1'b0, 8'hA5, 1'b0);
  endtask

  // Outputs settled after the edge that consumed the most recent drive
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset and acquisition from seed 0x01
    drive(0, 1'b1, 1'b0, 8'h00, 1'b0);
    settle();
    check_val("rst_locked", 32'(lk0), 32'd0);
    check_val("rst_err_count", 32'(ec0), 32'd0);
    check_val("rst_err_pulse", 32'(ep0), 32'd0);

    g = 8'h01;
    for (int i = 0; i < 8; i++) begin
      send(0, g); g = nxt(g);
    end
    settle();
    check_val("acq_not_yet", 32'(lk0), 32'd0);
    send(0, g); g = nxt(g);
    settle();
    check_val("acq_locked", 32'(lk0), 32'd1);
    check_val("acq_err_count", 32'(ec0), 32'd0);

    // Single corrupted byte
    send(0, ~g); g = nxt(g);
    settle();
    check_val("single_pulse", 32'(ep0), 32'd1);
    check_val("single_count", 32'(ec0), 32'd1);
    check_val("single_locked", 32'(lk0), 32'd1);
    send(0, g); g = nxt(g);
    settle();
    check_val("single_recover_pulse", 32'(ep0), 32'd0);

    // Four consecutive wrong bytes drop lock
    for (int i = 0; i < 4; i++) begin
      send(0, ~g); g = nxt(g);
    end
    settle();
    check_val("loss_locked", 32'(lk0), 32'd0);
    check_val("loss_count", 32'(ec0), 32'd5);
    for (int i = 0; i < 9; i++) begin
      send(0, g); g = nxt(g);
    end
    settle();
    check_val("relock_locked", 32'(lk0), 32'd1);
    check_val("relock_count", 32'(ec0), 32'd5);

    // Reset while locked, with a sample and clear present
    drive(0, 1'b1, 1'b1, 8'h00, 1'b1);
    settle();
    check_val("midrst_locked", 32'(lk0), 32'd0);
    check_val("midrst_count", 32'(ec0), 32'd0);

    // Lock-up byte in HUNT plus valid gaps
    g = 8'h01;
    for (int i = 0; i < 4; i++) begin
      send(0, g); g = nxt(g);
      gap(0, i + 1);
    end
    send(0, 8'hFF);
    gap(0, 5);
    for (int i = 0; i < 8; i++) begin
      send(0, g); g = nxt(g);
      gap(0, (i % 5) + 1);
    end
    check_val("ff_delay_locked", 32'(lk0), 32'd0);
    send(0, g); g = nxt(g);
    settle();
    check_val("ff_relock", 32'(lk0), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit v;
      bit clr;
      logic [7:0] d;
      v   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 30) == 0);
      d   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : g;
      drive(0, 1'b0, v, d, clr);
      if (v) g = nxt(g);
    end

    // Saturation on the never-drop-lock instance
    drive(1, 1'b1, 1'b0, 8'h00, 1'b0);
    g = 8'h01;
    for (int i = 0; i < 9; i++) begin
      send(1, g); g = nxt(g);
    end
    for (int i = 0; i < 65540; i++) begin
      send(1, ~g); g = nxt(g);
    end
    settle();
    check_val("sat_count", 32'(ec1), 32'h0000FFFF);
    check_val("sat_locked", 32'(lk1), 32'd1);
    drive(1, 1'b0, 1'b1, ~g, 1'b1); g = nxt(g);
    settle();
    check_val("clr_count", 32'(ec1), 32'd0);
    check_val("clr_pulse", 32'(ep1), 32'd1);

    gap(1, 2);
    settle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
